// File: rtl/usb_fs_sof_tx.sv
// usb_fs_sof_tx: full-speed USB Start-of-Frame token transmitter.
// One SOF packet (SYNC, PID, frame number, CRC5, EOP) is started every FRAME_PERIOD clocks.
// The packet is bit-stuffed and NRZI-encoded, then driven at 12 Mb/s (4 clocks per bit)
// from the 48 MHz clock. All line outputs are registered.
module usb_fs_sof_tx #(
   parameter int FRAME_PERIOD = 48000
) (
   input  logic        clk_48mhz,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_load,
   input  logic [10:0] frame_load_value,
   output logic        usb_p_tx,
   output logic        usb_n_tx,
   output logic        usb_tx_en,
   output logic [10:0] frame_index,
   output logic        sof_sent,
   output logic        busy
);

   localparam int            TW         = $clog2(FRAME_PERIOD);
   localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [7:0]    SYNC_BYTE  = 8'h80;
   localparam logic [7:0]    PID_SOF    = 8'hA5;
   localparam logic [4:0]    CRC5_INIT  = 5'h1F;
   localparam logic [4:0]    CRC5_POLY  = 5'h05;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_PID     = 3'd2,
      ST_FRAME   = 3'd3,
      ST_CRC     = 3'd4,
      ST_EOP_SE0 = 3'd5,
      ST_EOP_J   = 3'd6
   } state_t;

   // One serial step of CRC5 (x^5 + x^2 + 1), MSB-out shift register.
   function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
      logic fb;
      fb = crc[4] ^ din;
      return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
   endfunction

   // Fields that carry NRZI data (and therefore take part in bit stuffing).
   function automatic logic is_data(input state_t st);
      return (st == ST_SYNC) || (st == ST_PID) || (st == ST_FRAME) || (st == ST_CRC);
   endfunction

   // Index of the final bit time of each field.
   function automatic logic [3:0] last_bit(input state_t st);
      case (st)
         ST_SYNC:    return 4'd7;
         ST_PID:     return 4'd7;
         ST_FRAME:   return 4'd10;
         ST_CRC:     return 4'd4;
         ST_EOP_SE0: return 4'd1;
         default:    return 4'd0;
      endcase
   endfunction

   // Field sequence of one SOF packet; anything unexpected falls back to IDLE.
   function automatic state_t next_field(input state_t st);
      case (st)
         ST_SYNC:    return ST_PID;
         ST_PID:     return ST_FRAME;
         ST_FRAME:   return ST_CRC;
         ST_CRC:     return ST_EOP_SE0;
         ST_EOP_SE0: return ST_EOP_J;
         default:    return ST_IDLE;
      endcase
   endfunction

   // Raw (pre-NRZI) data bit for a field position; CRC goes out inverted, MSB first.
   function automatic logic field_bit(input state_t st, input logic [3:0] cnt,
                                      input logic [10:0] frame, input logic [4:0] crc);
      logic [2:0] idx;
      idx = 3'd4 - cnt[2:0];
      case (st)
         ST_SYNC:  return SYNC_BYTE[cnt[2:0]];
         ST_PID:   return PID_SOF[cnt[2:0]];
         ST_FRAME: return frame[cnt];
         ST_CRC:   return ~crc[idx];
         default:  return 1'b1;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          start_q, start_d;
   logic [1:0]    phase_q, phase_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]    stuff_cnt_q, stuff_cnt_d;
   logic          stuffing_q, stuffing_d;
   logic [10:0]   frame_lat_q, frame_lat_d;
   logic [4:0]    crc_q, crc_d;
   logic          line_q, line_d;
   logic [10:0]   frame_index_q, frame_index_d;
   logic          sof_sent_q, sof_sent_d;
   logic          tx_en_q, tx_en_d;
   logic          p_q, p_d;
   logic          n_q, n_d;
   logic          new_bit_s;
   logic          raw_cur_s;
   logic          raw_next_s;

   // Frame timer: counts while enabled and requests one packet per period.
   always_comb begin
      timer_d = {TW{1'b0}};
      start_d = 1'b0;
      if (enable) begin
         if (timer_q == TIMER_LAST) begin
            timer_d = {TW{1'b0}};
            start_d = 1'b1;
         end else begin
            timer_d = timer_q + TIMER_ONE;
            start_d = 1'b0;
         end
      end else begin
         timer_d = {TW{1'b0}};
         start_d = 1'b0;
      end
   end

   // Packet sequencer: bit phase, field position, stuffing, CRC, frame number and NRZI level.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      bit_cnt_d     = bit_cnt_q;
      stuff_cnt_d   = stuff_cnt_q;
      stuffing_d    = stuffing_q;
      frame_lat_d   = frame_lat_q;
      crc_d         = crc_q;
      frame_index_d = frame_index_q;
      sof_sent_d    = 1'b0;
      new_bit_s     = 1'b0;
      raw_next_s    = 1'b1;
      line_d        = line_q;
      raw_cur_s     = stuffing_q ? 1'b0 : field_bit(state_q, bit_cnt_q, frame_lat_q, crc_q);

      case (state_q)
         ST_IDLE: begin
            phase_d = 2'd0;
            if (start_q) begin
               state_d     = ST_SYNC;
               bit_cnt_d   = 4'd0;
               stuff_cnt_d = 3'd0;
               stuffing_d  = 1'b0;
               frame_lat_d = frame_index_q;
               crc_d       = CRC5_INIT;
               new_bit_s   = 1'b1;
            end else if (frame_load) begin
               frame_index_d = frame_load_value;
            end else begin
               frame_index_d = frame_index_q;
            end
         end
         default: begin
            phase_d = phase_q + 2'd1;
            // sof_sent lands on the final clock of EOP_J together with the frame increment
            if ((state_q == ST_EOP_J) && (phase_q == 2'd2)) begin
               sof_sent_d    = 1'b1;
               frame_index_d = frame_index_q + 11'd1;
            end else begin
               sof_sent_d    = 1'b0;
            end
            if (phase_q == 2'd3) begin
               new_bit_s = 1'b1;
               if (stuffing_q) begin
                  // the field position already points past the bit that caused the stuff
                  stuffing_d  = 1'b0;
                  stuff_cnt_d = 3'd0;
               end else begin
                  if (state_q == ST_FRAME) begin
                     crc_d = crc5_step(crc_q, raw_cur_s);
                  end else begin
                     crc_d = crc_q;
                  end
                  if (bit_cnt_q == last_bit(state_q)) begin
                     bit_cnt_d = 4'd0;
                     state_d   = next_field(state_q);
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
                  if (is_data(state_q) && raw_cur_s) begin
                     if (stuff_cnt_q == 3'd5) begin
                        stuffing_d  = 1'b1;
                        stuff_cnt_d = 3'd0;
                     end else begin
                        stuff_cnt_d = stuff_cnt_q + 3'd1;
                     end
                  end else begin
                     stuff_cnt_d = 3'd0;
                  end
               end
            end else begin
               new_bit_s = 1'b0;
            end
         end
      endcase

      // NRZI: a raw 0 toggles the line, a raw 1 holds it; outside data the level rests at J
      if (new_bit_s) begin
         if (stuffing_d) begin
            raw_next_s = 1'b0;
         end else begin
            raw_next_s = field_bit(state_d, bit_cnt_d, frame_lat_d, crc_d);
         end
         if (stuffing_d || is_data(state_d)) begin
            line_d = raw_next_s ? line_q : ~line_q;
         end else begin
            line_d = 1'b1;
         end
      end else begin
         line_d = line_q;
      end
   end

   // Line drivers: decode the upcoming state into D+/D-/output-enable levels.
   always_comb begin
      tx_en_d = 1'b1;
      p_d     = 1'b1;
      n_d     = 1'b0;
      if (stuffing_d || is_data(state_d)) begin
         p_d = line_d;
         n_d = ~line_d;
      end else begin
         case (state_d)
            ST_EOP_SE0: begin
               p_d = 1'b0;
               n_d = 1'b0;
            end
            ST_EOP_J: begin
               p_d = 1'b1;
               n_d = 1'b0;
            end
            default: begin
               tx_en_d = 1'b0;
               p_d     = 1'b1;
               n_d     = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset; reset aborts any packet at once.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         timer_q       <= {TW{1'b0}};
         start_q       <= 1'b0;
         phase_q       <= 2'd0;
         bit_cnt_q     <= 4'd0;
         stuff_cnt_q   <= 3'd0;
         stuffing_q    <= 1'b0;
         frame_lat_q   <= 11'd0;
         crc_q         <= CRC5_INIT;
         line_q        <= 1'b1;
         frame_index_q <= 11'd0;
         sof_sent_q    <= 1'b0;
         tx_en_q       <= 1'b0;
         p_q           <= 1'b1;
         n_q           <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         start_q       <= start_d;
         phase_q       <= phase_d;
         bit_cnt_q     <= bit_cnt_d;
         stuff_cnt_q   <= stuff_cnt_d;
         stuffing_q    <= stuffing_d;
         frame_lat_q   <= frame_lat_d;
         crc_q         <= crc_d;
         line_q        <= line_d;
         frame_index_q <= frame_index_d;
         sof_sent_q    <= sof_sent_d;
         tx_en_q       <= tx_en_d;
         p_q           <= p_d;
         n_q           <= n_d;
      end
   end

   assign usb_p_tx    = p_q;
   assign usb_n_tx    = n_q;
   assign usb_tx_en   = tx_en_q;
   assign busy        = tx_en_q;
   assign frame_index = frame_index_q;
   assign sof_sent    = sof_sent_q;

endmodule

// File: tb/tb_usb_fs_sof_tx.sv
// Testbench for usb_fs_sof_tx: random frame numbers checked against a bit-level packet model
// (raw field bits -> stuffing -> NRZI -> per-clock line waveform) and an independent decoder.
`timescale 1ns/1ps
module tb_usb_fs_sof_tx;

   localparam int FP = 256;

   logic        clk_48mhz = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        frame_load = 1'b0;
   logic [10:0] frame_load_value = 11'd0;
   logic        usb_p_tx, usb_n_tx, usb_tx_en, sof_sent, busy;
   logic [10:0] frame_index;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [3:0] exp_q[$];

   usb_fs_sof_tx #(.FRAME_PERIOD(FP)) dut (
      .clk_48mhz       (clk_48mhz),
      .reset           (reset),
      .enable          (enable),
      .frame_load      (frame_load),
      .frame_load_value(frame_load_value),
      .usb_p_tx        (usb_p_tx),
      .usb_n_tx        (usb_n_tx),
      .usb_tx_en       (usb_tx_en),
      .frame_index     (frame_index),
      .sof_sent        (sof_sent),
      .busy            (busy)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_48mhz);
      #1;
      cyc++;
   endtask

   // USB CRC5 as polynomial division, one bit at a time.
   function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
      logic [4:0] r;
      r = {c[3:0], 1'b0};
      if (c[4] ^ b) r = r ^ 5'b00101;
      return r;
   endfunction

   // Expected {busy, tx_en, p, n} for every clock of the packet carrying frame f.
   task automatic build_expected(input logic [10:0] f);
      logic       bits[$];
      logic       raw[$];
      logic [7:0] sync_b;
      logic [7:0] pid_b;
      logic [4:0] c;
      logic       lvl;
      int         run;
      sync_b = 8'h80;
      pid_b  = 8'hA5;
      c      = 5'h1F;
      for (int i = 0; i < 8; i++) bits.push_back(sync_b[i]);
      for (int i = 0; i < 8; i++) bits.push_back(pid_b[i]);
      for (int i = 0; i < 11; i++) begin
         bits.push_back(f[i]);
         c = crc_step(c, f[i]);
      end
      for (int i = 4; i >= 0; i--) bits.push_back(~c[i]);
      run = 0;
      foreach (bits[i]) begin
         raw.push_back(bits[i]);
         run = bits[i] ? run + 1 : 0;
         if (run == 6) begin
            raw.push_back(1'b0);
            run = 0;
         end
      end
      exp_q.delete();
      lvl = 1'b1;
      foreach (raw[i]) begin
         if (!raw[i]) lvl = ~lvl;
         repeat (4) exp_q.push_back({2'b11, lvl, ~lvl});
      end
      repeat (8) exp_q.push_back(4'b1100);
      repeat (4) exp_q.push_back(4'b1110);
   endtask

   task automatic wait_rise(output int n);
      n = 0;
      while (usb_tx_en !== 1'b1 && n < 4 * FP) begin
         tick();
         n++;
      end
      if (usb_tx_en !== 1'b1) check_val("rise_timeout", 32'(usb_tx_en), 32'd1);
   endtask

   // Capture one packet from its first clock; optionally pulse frame_load or drop enable mid-packet.
   task automatic run_packet(input logic [10:0] f, input int load_at, input logic [10:0] load_val,
                             input int dis_at, input string tag);
      logic [3:0] cap[$];
      logic       raw[$];
      logic       dat[$];
      logic       prev, lvl, skip;
      int         idx, sof_cnt, sof_idx, n, ones, max_ones;
      logic [7:0] fld8;
      logic [10:0] fld11;
      logic [4:0] c;
      idx = 0; sof_cnt = 0; sof_idx = -1;
      build_expected(f);
      while (usb_tx_en === 1'b1 && idx < 400) begin
         cap.push_back({busy, usb_tx_en, usb_p_tx, usb_n_tx});
         if (sof_sent === 1'b1) begin
            sof_cnt++;
            sof_idx = idx;
         end
         if (idx == load_at) begin
            frame_load = 1'b1;
            frame_load_value = load_val;
         end else begin
            frame_load = 1'b0;
         end
         if (idx == dis_at) enable = 1'b0;
         tick();
         idx++;
      end
      frame_load = 1'b0;
      check_val({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
      n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_val($sformatf("%s_wave%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
      check_val({tag, "_sof_cnt"}, 32'(sof_cnt), 32'd1);
      check_val({tag, "_sof_idx"}, 32'(sof_idx), 32'(exp_q.size() - 1));
      check_val({tag, "_idle_lines"}, 32'({busy, usb_tx_en, usb_p_tx, usb_n_tx}), 32'b0010);
      check_val({tag, "_next_frame"}, 32'(frame_index), 32'(11'(f + 11'd1)));
      // independent decode of the captured line: NRZI, destuff, field extraction
      prev = 1'b1;
      for (int i = 1; i < cap.size(); i += 4) begin
         if (cap[i][1:0] == 2'b00) break;
         lvl = cap[i][1];
         raw.push_back(lvl == prev);
         prev = lvl;
      end
      ones = 0; max_ones = 0; skip = 1'b0;
      foreach (raw[i]) begin
         ones = raw[i] ? ones + 1 : 0;
         if (ones > max_ones) max_ones = ones;
      end
      ones = 0;
      foreach (raw[i]) begin
         if (skip) begin
            check_val({tag, "_stuff_zero"}, 32'(raw[i]), 32'd0);
            skip = 1'b0;
            ones = 0;
         end else begin
            dat.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) skip = 1'b1;
         end
      end
      check_val({tag, "_max_run"}, 32'(max_ones <= 6), 32'd1);
      check_val({tag, "_raw_bits"}, 32'(raw.size()), 32'((exp_q.size() - 12) / 4));
      if (f == 11'h7FF) check_val({tag, "_has_stuff"}, 32'(raw.size() > 32), 32'd1);
      check_val({tag, "_data_bits"}, 32'(dat.size()), 32'd32);
      if (dat.size() >= 32) begin
         for (int i = 0; i < 8; i++) fld8[i] = dat[i];
         check_val({tag, "_sync"}, 32'(fld8), 32'h80);
         for (int i = 0; i < 8; i++) fld8[i] = dat[8 + i];
         check_val({tag, "_pid"}, 32'(fld8), 32'hA5);
         for (int i = 0; i < 11; i++) fld11[i] = dat[16 + i];
         check_val({tag, "_frame"}, 32'(fld11), 32'(f));
         c = 5'h1F;
         for (int i = 16; i < 32; i++) c = crc_step(c, dat[i]);
         check_val({tag, "_crc_residual"}, 32'(c), 32'b01100);
      end
   endtask

   task automatic load_idle(input logic [10:0] v);
      frame_load = 1'b1;
      frame_load_value = v;
      tick();
      frame_load = 1'b0;
      check_val("load_idle", 32'(frame_index), 32'(v));
   endtask

   initial begin
      int t, r0, hi;
      logic [10:0] v, cur;

      // reset
      reset = 1'b1;
      repeat (3) tick();
      check_val("rst_out", 32'({busy, usb_tx_en, usb_p_tx, usb_n_tx, sof_sent}), 32'b00100);
      check_val("rst_frame", 32'(frame_index), 32'd0);

      // first SOF timing and frame 0, then period to frame 1
      reset = 1'b0;
      enable = 1'b1;
      wait_rise(t);
      check_val("first_rise", 32'(t), 32'(FP + 1));
      r0 = cyc;
      run_packet(11'd0, -1, 11'd0, -1, "f0");
      wait_rise(t);
      check_val("period", 32'(cyc - r0), 32'(FP));
      run_packet(11'd1, -1, 11'd0, -1, "f1");

      // wrap at 0x7FF
      load_idle(11'h7FF);
      wait_rise(t);
      run_packet(11'h7FF, -1, 11'd0, -1, "f7ff");
      wait_rise(t);
      run_packet(11'h000, -1, 11'd0, -1, "fwrap");

      // random frame numbers
      for (int k = 0; k < 4; k++) begin
         v = 11'($urandom_range(0, 2047));
         load_idle(v);
         wait_rise(t);
         run_packet(v, -1, 11'd0, -1, $sformatf("rnd%0d", k));
      end

      // load while busy is ignored, then honoured in idle
      wait_rise(t);
      cur = frame_index;
      run_packet(cur, 20, 11'h123, -1, "busyload");
      wait_rise(t);
      run_packet(11'(cur + 11'd1), -1, 11'd0, -1, "afterbusy");
      load_idle(11'h123);
      wait_rise(t);
      run_packet(11'h123, -1, 11'd0, -1, "f123");

      // enable dropped inside the FRAME field
      wait_rise(t);
      cur = frame_index;
      run_packet(cur, -1, 11'd0, 70, "dis");
      hi = 0;
      repeat (3 * FP) begin
         tick();
         if (usb_tx_en === 1'b1) hi++;
      end
      check_val("quiet", 32'(hi), 32'd0);
      enable = 1'b1;
      wait_rise(t);
      check_val("reenable_rise", 32'(t), 32'(FP + 1));
      run_packet(11'(cur + 11'd1), -1, 11'd0, -1, "reen");

      // reset inside the CRC field
      wait_rise(t);
      repeat (116) tick();
      check_val("pre_rst_busy", 32'(usb_tx_en), 32'd1);
      reset = 1'b1;
      tick();
      check_val("midrst_lines", 32'({busy, usb_tx_en, usb_p_tx, usb_n_tx}), 32'b0010);
      check_val("midrst_frame", 32'(frame_index), 32'd0);
      reset = 1'b0;
      wait_rise(t);
      check_val("postrst_rise", 32'(t), 32'(FP + 1));
      run_packet(11'd0, -1, 11'd0, -1, "postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
